axi_lite_regfile: RTL and testbench
===================================

// Module: axi_lite_regfile
// PURPOSE
//   Parametrised AXI4-Lite slave register file with full read and write channels.
//   Holds NUM_REGS registers of DATA_W bits, each writable through byte strobes.
//   Register contents are also driven out in parallel for control logic.
//   Sits between the AXI-Lite interconnect and block-level control/status fabric.
// PARAMETERS
//   DATA_W    32  data width; must be 32 or 64
//   ADDR_W    6   byte address width; must satisfy NUM_REGS <= 2**(ADDR_W-2)
//   NUM_REGS  8   number of implemented registers; must be >= 1
// PORTS
//   axi_aclk     in   1              single clock, all logic on the rising edge
//   axi_aresetn  in   1              reset, asynchronous assert, active-low
//   axi_awaddr   in   ADDR_W         write address
//   axi_awvalid  in   1              write address valid
//   axi_awready  out  1              write address ready
//   axi_wdata    in   DATA_W         write data
//   axi_wstrb    in   DATA_W/8       byte write strobes
//   axi_wvalid   in   1              write data valid
//   axi_wready   out  1              write data ready
//   axi_bresp    out  2              write response
//   axi_bvalid   out  1              write response valid
//   axi_bready   in   1              write response ready
//   axi_araddr   in   ADDR_W         read address
//   axi_arvalid  in   1              read address valid
//   axi_arready  out  1              read address ready
//   axi_rdata    out  DATA_W         read data
//   axi_rresp    out  2              read response
//   axi_rvalid   out  1              read data valid
//   axi_rready   in   1              read data ready
//   regs_out     out  NUM_REGS*DATA_W  parallel register contents; reg i is at [i*DATA_W +: DATA_W]
// BEHAVIOUR
//   - Reset: every register = 0. Every output = 0, including all readies.
//     arready, awready and wready rise on the first clock edge after axi_aresetn deasserts.
//   - Decode: index = addr[ADDR_W-1:2]; addr[1:0] ignored. index >= NUM_REGS is out-of-range.
//   - Read FSM, R_IDLE -> R_DATA -> R_IDLE:
//       R_IDLE: arready=1. A handshake (arvalid & arready) moves to R_DATA, drops arready,
//         and registers rdata/rresp from the current contents. Out-of-range index gives rdata=0.
//       R_DATA: rvalid=1. rdata and rresp hold stable until rready. rvalid & rready returns
//         to R_IDLE, clears rvalid, and raises arready on the same edge.
//       Latency: rvalid is asserted 1 cycle after the AR handshake. Max 1 outstanding read.
//   - Write FSM, W_IDLE -> W_RESP -> W_IDLE:
//       AW and W handshake independently, in either order or in the same cycle.
//       awready drops once AW is captured; wready drops once W is captured.
//       On the edge where both are held, the write commits: bytes with wstrb[b]=1 are
//         updated, bytes with strobe 0 are kept. Out-of-range writes are dropped.
//       bvalid is asserted 1 cycle after the commit and holds until bready.
//       bvalid & bready clears bvalid and raises awready and wready. Max 1 outstanding write.
//   - Read and write on the same cycle to the same index: the read returns the pre-write value.
//   - regs_out reflects a committed write 1 cycle after the commit edge.
//   - Reset mid-transaction: the transaction is aborted, both FSMs return to IDLE,
//     and all registers clear.
//   - rresp and bresp are 2'b00 (OKAY) unless AXIL_SLVERR_EN is defined.
// CONFIGURATION
//   AXIL_SLVERR_EN defined: an out-of-range read returns rresp=2'b10 (SLVERR) with rdata=0.
//     An out-of-range write returns bresp=2'b10 and is dropped.
//   AXIL_SLVERR_EN undefined: all responses are 2'b00. Out-of-range reads return 0,
//     and out-of-range writes are silently dropped.
// TESTING
//   - Reset, then read addr 0x04 with rready=1 -> arready=1 at idle; rvalid 1 cycle after
//     handshake; rdata=0; rresp=0.
//   - Write 0xDEADBEEF to 0x08 with wstrb=4'hF, AW and W in the same cycle, then read 0x08
//     -> bvalid next cycle, bresp=0; rdata=0xDEADBEEF; regs_out[2]=0xDEADBEEF.
//   - W sent 3 cycles before AW, wdata=0x000000AA, wstrb=4'b0001, to 0x08 holding 0xDEADBEEF
//     -> wready low after W; reg becomes 0xDEADBEAA.
//   - Read 0x0C with rready held 0 for 5 cycles -> rvalid and rdata stable throughout;
//     arready=0 until the R handshake.
//   - Write 0x3C (index 15 >= 8) -> no register changes; bresp=2'b10 with AXIL_SLVERR_EN,
//     else 2'b00. Read 0x3C -> rdata=0, rresp per the same rule.
//   - Assert axi_aresetn=0 while bvalid=1 -> bvalid=0 immediately; all regs_out=0;
//     readies high 1 cycle after release.

Source files
------------

// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: AXI4-Lite slave register file with byte-strobed writes
// and a parallel snapshot of all registers for control logic.
//
// Optional feature macro: AXIL_SLVERR_EN
//   defined   -> out-of-range reads/writes answer SLVERR (2'b10)
//   undefined -> every response is OKAY (2'b00)
//
// Read FSM
//   state  | meaning
//   R_RST  | first cycle out of reset, arready held low
//   R_IDLE | arready=1, waiting for an AR handshake
//   R_DATA | rvalid=1, rdata/rresp held until rready
//
// Write FSM
//   state  | meaning
//   W_RST  | first cycle out of reset, awready/wready held low
//   W_IDLE | collecting AW and W in any order; commit once both are present
//   W_RESP | bvalid=1, bresp held until bready
module axi_lite_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = 8
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic [ADDR_W-1:0]            axi_awaddr,
  input  logic                         axi_awvalid,
  output logic                         axi_awready,
  input  logic [DATA_W-1:0]            axi_wdata,
  input  logic [DATA_W/8-1:0]          axi_wstrb,
  input  logic                         axi_wvalid,
  output logic                         axi_wready,
  output logic [1:0]                   axi_bresp,
  output logic                         axi_bvalid,
  input  logic                         axi_bready,
  input  logic [ADDR_W-1:0]            axi_araddr,
  input  logic                         axi_arvalid,
  output logic                         axi_arready,
  output logic [DATA_W-1:0]            axi_rdata,
  output logic [1:0]                   axi_rresp,
  output logic                         axi_rvalid,
  input  logic                         axi_rready,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int STRB_W = DATA_W / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_RST, R_IDLE, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_RST, W_IDLE, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic              aw_held, w_held;
  logic [IDX_W-1:0]  aw_idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rresp_q, bresp_q;

  logic              ar_hs, r_hs, aw_hs, w_hs, b_hs, commit;
  logic [IDX_W-1:0]  ar_idx, wr_idx;
  logic [DATA_W-1:0] wr_data, rd_mux;
  logic [STRB_W-1:0] wr_strb;
  logic [1:0]        rd_resp_nxt, wr_resp_nxt;

  // The low address bits only select a byte lane inside a register.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{axi_awaddr[1:0], axi_araddr[1:0]};

  assign axi_arready = (r_state == R_IDLE);
  assign axi_rvalid  = (r_state == R_DATA);
  assign axi_awready = (w_state == W_IDLE) && !aw_held;
  assign axi_wready  = (w_state == W_IDLE) && !w_held;
  assign axi_bvalid  = (w_state == W_RESP);
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_bresp   = bresp_q;

  assign ar_hs  = axi_arvalid && axi_arready;
  assign r_hs   = axi_rvalid  && axi_rready;
  assign aw_hs  = axi_awvalid && axi_awready;
  assign w_hs   = axi_wvalid  && axi_wready;
  assign b_hs   = axi_bvalid  && axi_bready;
  assign commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);

  // A channel captured on an earlier edge wins over the live bus value.
  assign ar_idx  = axi_araddr[ADDR_W-1:2];
  assign wr_idx  = aw_held ? aw_idx_q : axi_awaddr[ADDR_W-1:2];
  assign wr_data = w_held  ? wdata_q  : axi_wdata;
  assign wr_strb = w_held  ? wstrb_q  : axi_wstrb;

`ifdef AXIL_SLVERR_EN
  assign rd_resp_nxt = (32'(ar_idx) < 32'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
  assign wr_resp_nxt = (32'(wr_idx) < 32'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;
`else
  assign rd_resp_nxt = RESP_OKAY;
  assign wr_resp_nxt = RESP_OKAY;
`endif

  // Read mux; an index with no matching register falls through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) rd_mux = regs[i];
    end
  end

  // State registers for both channel FSMs.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= R_RST;
      w_state <= W_RST;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // Read FSM next state.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_RST:   r_next = R_IDLE;
      R_IDLE:  if (ar_hs) r_next = R_DATA;
      R_DATA:  if (r_hs)  r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Write FSM next state.
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_RST:   w_next = W_IDLE;
      W_IDLE:  if (commit) w_next = W_RESP;
      W_RESP:  if (b_hs)   w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Channel capture, read data/response and write response registers.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      bresp_q  <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        rdata_q <= rd_mux;
        rresp_q <= rd_resp_nxt;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= wr_resp_nxt;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= axi_awaddr[ADDR_W-1:2];
        end
        if (w_hs) begin
          w_held  <= 1'b1;
          wdata_q <= axi_wdata;
          wstrb_q <= axi_wstrb;
        end
      end
    end
  end

  // Register storage; out-of-range indices match no register and are dropped.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_idx == IDX_W'(i) && wr_strb[b]) regs[i][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_W +: DATA_W] = regs[g];
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (DATA_W=32, ADDR_W=6, NUM_REGS=8).
module tb_axi_lite_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [255:0] regs_out;

  int n_pass = 0;
  int n_total = 0;

`ifdef AXIL_SLVERR_EN
  localparam logic [1:0] EXP_OOR = 2'b10;
`else
  localparam logic [1:0] EXP_OOR = 2'b00;
`endif

  axi_lite_regfile #(.DATA_W(32), .ADDR_W(6), .NUM_REGS(8)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axi_awaddr(awaddr), .axi_awvalid(awvalid), .axi_awready(awready),
    .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
    .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
    .axi_araddr(araddr), .axi_arvalid(arvalid), .axi_arready(arready),
    .axi_rdata(rdata), .axi_rresp(rresp), .axi_rvalid(rvalid), .axi_rready(rready),
    .regs_out(regs_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_read(input logic [5:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int lat);
    int k;
    araddr = a; arvalid = 1'b1; rready = 1'b1; k = 0;
    while (!arready && k < 20) begin tick(); k++; end
    if (k >= 20) begin n_total++; $display("FAIL ar_timeout addr=%h", a); end
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    d = rdata; resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int lat);
    int k;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0; k = 0;
    while (!(awready && wready) && k < 20) begin tick(); k++; end
    if (k >= 20) begin n_total++; $display("FAIL aw_w_timeout addr=%h", a); end
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 1;
    while (!bvalid && lat < 20) begin tick(); lat++; end
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; int lat;
    rst_n = 1'b0;
    tick(); tick();
    n_total++;
    if ({arready, awready, wready, bvalid, rvalid} !== 5'b0)
      $display("FAIL reset_outputs got %b want 00000", {arready, awready, wready, bvalid, rvalid});
    else n_pass++;
    n_total++;
    if (regs_out !== '0) $display("FAIL reset_regs got %h want 0", regs_out); else n_pass++;
    rst_n = 1'b1;
    n_total++;
    if (arready !== 1'b0) $display("FAIL ready_before_edge got %b want 0", arready); else n_pass++;
    tick();
    n_total++;
    if ({arready, awready, wready} !== 3'b111)
      $display("FAIL ready_after_release got %b want 111", {arready, awready, wready});
    else n_pass++;
    axi_read(6'h04, d, r, lat);
    n_total++;
    if (lat !== 1) $display("FAIL rd_latency got %0d want 1", lat); else n_pass++;
    n_total++;
    if ({r, d} !== 34'h0) $display("FAIL rd_reset_val got resp=%b data=%h want 0/0", r, d); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic [1:0] r; int lat;
    axi_write(6'h08, 32'hDEADBEEF, 4'hF, r, lat);
    n_total++;
    if (lat !== 1 || r !== 2'b00) $display("FAIL wr_latency_resp got lat=%0d resp=%b want 1/00", lat, r); else n_pass++;
    n_total++;
    if ({awready, wready, bvalid} !== 3'b110)
      $display("FAIL wr_return_idle got %b want 110", {awready, wready, bvalid});
    else n_pass++;
    n_total++;
    if (regs_out[2*32 +: 32] !== 32'hDEADBEEF) $display("FAIL regs_out2 got %h want deadbeef", regs_out[2*32 +: 32]); else n_pass++;
    axi_read(6'h08, d, r, lat);
    n_total++;
    if (d !== 32'hDEADBEEF || r !== 2'b00) $display("FAIL rd_reg2 got %h/%b want deadbeef/00", d, r); else n_pass++;
  endtask

  task automatic test_w_before_aw();
    awaddr = 6'h08; wdata = 32'h000000AA; wstrb = 4'b0001; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    n_total++;
    if ({wready, awready, bvalid} !== 3'b010)
      $display("FAIL w_first_ready got %b want 010", {wready, awready, bvalid});
    else n_pass++;
    tick(); tick();
    n_total++;
    if (regs_out[2*32 +: 32] !== 32'hDEADBEEF) $display("FAIL w_first_early got %h want deadbeef", regs_out[2*32 +: 32]); else n_pass++;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    n_total++;
    if ({bvalid, awready, wready} !== 3'b100)
      $display("FAIL w_first_bvalid got %b want 100", {bvalid, awready, wready});
    else n_pass++;
    n_total++;
    if (regs_out[2*32 +: 32] !== 32'hDEADBEAA) $display("FAIL w_first_merge got %h want deadbeaa", regs_out[2*32 +: 32]); else n_pass++;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    n_total++;
    if ({bvalid, awready, wready} !== 3'b011)
      $display("FAIL w_first_bdone got %b want 011", {bvalid, awready, wready});
    else n_pass++;
  endtask

  task automatic test_strobes();
    logic [1:0] r; int lat;
    axi_write(6'h0C, 32'h12345678, 4'hF, r, lat);
    axi_write(6'h0C, 32'hAABBCCDD, 4'b0110, r, lat);
    n_total++;
    if (regs_out[3*32 +: 32] !== 32'h12BBCC78) $display("FAIL strb_0110 got %h want 12bbcc78", regs_out[3*32 +: 32]); else n_pass++;
  endtask

  task automatic test_read_stall();
    araddr = 6'h0C; arvalid = 1'b1; rready = 1'b0;
    n_total++;
    if (arready !== 1'b1) $display("FAIL stall_arready_idle got %b want 1", arready); else n_pass++;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({rvalid, arready} !== 2'b10 || rdata !== 32'h12BBCC78)
        $display("FAIL stall_hold cyc=%0d got rv/ar=%b data=%h want 10/12bbcc78", i, {rvalid, arready}, rdata);
      else n_pass++;
      tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    n_total++;
    if ({rvalid, arready} !== 2'b01) $display("FAIL stall_release got %b want 01", {rvalid, arready}); else n_pass++;
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    logic [255:0] exp_regs;
    axi_write(6'h1C, 32'h00000077, 4'hF, r, lat);
    n_total++;
    if (r !== 2'b00) $display("FAIL wr_idx7_resp got %b want 00", r); else n_pass++;
    axi_write(6'h3C, 32'hFFFFFFFF, 4'hF, r, lat);
    n_total++;
    if (r !== EXP_OOR) $display("FAIL wr_oor15_resp got %b want %b", r, EXP_OOR); else n_pass++;
    axi_write(6'h20, 32'hFFFFFFFF, 4'hF, r, lat);
    n_total++;
    if (r !== EXP_OOR) $display("FAIL wr_oor8_resp got %b want %b", r, EXP_OOR); else n_pass++;
    exp_regs = '0;
    exp_regs[2*32 +: 32] = 32'hDEADBEAA;
    exp_regs[3*32 +: 32] = 32'h12BBCC78;
    exp_regs[7*32 +: 32] = 32'h00000077;
    n_total++;
    if (regs_out !== exp_regs) $display("FAIL oor_no_change got %h want %h", regs_out, exp_regs); else n_pass++;
    axi_read(6'h3C, d, r, lat);
    n_total++;
    if (d !== 32'h0 || r !== EXP_OOR) $display("FAIL rd_oor got %h/%b want 0/%b", d, r, EXP_OOR); else n_pass++;
    axi_read(6'h1C, d, r, lat);
    n_total++;
    if (d !== 32'h77 || r !== 2'b00) $display("FAIL rd_idx7 got %h/%b want 77/00", d, r); else n_pass++;
    axi_read(6'h0B, d, r, lat);
    n_total++;
    if (d !== 32'hDEADBEAA) $display("FAIL rd_lsb_ignored got %h want deadbeaa", d); else n_pass++;
  endtask

  task automatic test_same_cycle_rw();
    awaddr = 6'h08; wdata = 32'h0BADF00D; wstrb = 4'hF; araddr = 6'h08;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    n_total++;
    if ({rvalid, bvalid} !== 2'b11 || rdata !== 32'hDEADBEAA)
      $display("FAIL rw_pre_write got rv/bv=%b data=%h want 11/deadbeaa", {rvalid, bvalid}, rdata);
    else n_pass++;
    n_total++;
    if (regs_out[2*32 +: 32] !== 32'h0BADF00D) $display("FAIL rw_commit got %h want 0badf00d", regs_out[2*32 +: 32]); else n_pass++;
    tick();
    rready = 1'b0; bready = 1'b0;
    n_total++;
    if ({rvalid, bvalid, arready, awready, wready} !== 5'b00111)
      $display("FAIL rw_idle got %b want 00111", {rvalid, bvalid, arready, awready, wready});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    awaddr = 6'h14; wdata = 32'h55555555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    n_total++;
    if (bvalid !== 1'b1) $display("FAIL mid_bvalid_pre got %b want 1", bvalid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({bvalid, arready, awready, wready} !== 4'b0) $display("FAIL mid_reset_outs got %b want 0000", {bvalid, arready, awready, wready}); else n_pass++;
    n_total++;
    if (regs_out !== '0) $display("FAIL mid_reset_regs got %h want 0", regs_out); else n_pass++;
    tick();
    rst_n = 1'b1;
    n_total++;
    if ({arready, awready, wready} !== 3'b000) $display("FAIL mid_ready_early got %b want 000", {arready, awready, wready}); else n_pass++;
    tick();
    n_total++;
    if ({arready, awready, wready} !== 3'b111) $display("FAIL mid_ready_after got %b want 111", {arready, awready, wready}); else n_pass++;
    axi_read(6'h14, d, r, lat);
    n_total++;
    if (d !== 32'h0) $display("FAIL mid_aborted_write got %h want 0", d); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_w_before_aw();
    test_strobes();
    test_read_stall();
    test_out_of_range();
    test_same_cycle_rw();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
